// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - run/step/direction pushbutton controller for a 4-bit up/down counter
// Optional feature: define AUTO_REVERSE_EN to flip count_dir at the count end points.
module counter_ctrl #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       btn_dir,
  input  logic [3:0] count,
  output logic       enable,
  output logic       count_dir
);

  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  // Bit 0 = run, bit 1 = step, bit 2 = dir throughout.
  logic [2:0] raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] level_q, level_d, level_dly_q, press_q;
  logic [7:0] db_cnt_q [3];
  logic [7:0] db_cnt_d [3];

  state_t state_q, state_d;
  logic   enable_q, enable_d;
  logic   dir_q, dir_d;

  assign raw       = {btn_dir, btn_step, btn_run};
  assign enable    = enable_q;
  assign count_dir = dir_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      level_d[i]  = level_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (press_q[0]) begin
          state_d = RUN;
        end else if (press_q[1]) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (press_q[0]) begin
          state_d = IDLE;
        end
      end
      STEP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    enable_d = (state_d != IDLE);

    dir_d = dir_q;
    if (press_q[2]) begin
      dir_d = ~dir_q;
    end
`ifdef AUTO_REVERSE_EN
    else if (enable_q && dir_q && (count == 4'hF)) begin
      dir_d = 1'b0;
    end else if (enable_q && !dir_q && (count == 4'h0)) begin
      dir_d = 1'b1;
    end
`endif
  end

`ifndef AUTO_REVERSE_EN
  logic unused_count;
  assign unused_count = ^count;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      press_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q  <= IDLE;
      enable_q <= 1'b0;
      dir_q    <= 1'b1;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      // Rising edge of the debounced level only; releases are silent.
      press_q     <= level_q & ~level_dly_q;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q  <= state_d;
      enable_q <= enable_d;
      dir_q    <= dir_d;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl (table vectors, corner sequences, random vs model)
module tb_counter_ctrl;

  localparam int DB = 4;
`ifdef AUTO_REVERSE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_run, btn_step, btn_dir;
  logic [3:0] count;
  logic       enable, count_dir;

  always #5 clk = ~clk;

  counter_ctrl #(.DB_CYCLES(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .btn_dir  (btn_dir),
    .count    (count),
    .enable   (enable),
    .count_dir(count_dir)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: raw samples per edge; a level flips once the last DB
  // synchronized samples (raw delayed two edges) all oppose it; the FSM acts
  // on that press two edges later.
  bit [2:0] m_hist[$];
  bit [2:0] m_level, m_p1, m_p2;
  int       m_mode;   // 0 idle, 1 run, 2 step
  bit       m_en, m_dir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_hist.delete();
    m_level = '0;
    m_p1    = '0;
    m_p2    = '0;
    m_mode  = 0;
    m_en    = 1'b0;
    m_dir   = 1'b1;
  endtask

  function automatic bit hist_at(input int back, input int b);
    int idx;
    idx = m_hist.size() - 1 - back;
    if (idx < 0) return 1'b0;
    return m_hist[idx][b];
  endfunction

  task automatic model_edge();
    bit [2:0] act;
    bit [2:0] rises;
    bit       all_opp;
    bit       old_en;
    if (reset) begin
      model_clear();
      return;
    end
    act   = m_p2;
    rises = '0;
    m_hist.push_back({btn_dir, btn_step, btn_run});
    if (m_hist.size() > 64) void'(m_hist.pop_front());
    for (int b = 0; b < 3; b++) begin
      all_opp = 1'b1;
      for (int j = 0; j < DB; j++) begin
        if (hist_at(2 + j, b) == m_level[b]) all_opp = 1'b0;
      end
      if (all_opp) begin
        if (!m_level[b]) rises[b] = 1'b1;
        m_level[b] = ~m_level[b];
      end
    end
    old_en = m_en;
    if (act[2]) m_dir = !m_dir;
    else if (AUTO && old_en && m_dir && count == 4'hF) m_dir = 1'b0;
    else if (AUTO && old_en && !m_dir && count == 4'h0) m_dir = 1'b1;
    case (m_mode)
      0: if (act[0]) m_mode = 1; else if (act[1]) m_mode = 2;
      1: if (act[0]) m_mode = 0;
      default: m_mode = 0;
    endcase
    m_en = (m_mode != 0);
    m_p2 = m_p1;
    m_p1 = rises;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_enable", enable, m_en);
    check("model_count_dir", count_dir, m_dir);
  endtask

  task automatic set_btn(input bit [2:0] v);
    btn_run  = v[0];
    btn_step = v[1];
    btn_dir  = v[2];
  endtask

  task automatic hold(input bit [2:0] v, input int n);
    set_btn(v);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    model_clear();
    #1;
    check("async_reset_enable", enable, 0);
    check("async_reset_dir", count_dir, 1);
    repeat (n) tick();
    reset = 1'b0;
  endtask

  typedef struct {
    bit [2:0] btn;
    int       hold_n;
    bit       exp_en;
    bit       exp_dir;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int   first_en, first_dir, hi;
    int   rem[3];
    bit   val[3];

    vecs = '{
      '{3'b001, 3,  1'b0, 1'b1},   // glitch shorter than DB: ignored
      '{3'b001, 10, 1'b1, 1'b1},   // run
      '{3'b001, 10, 1'b0, 1'b1},   // stop
      '{3'b010, 10, 1'b0, 1'b1},   // single step, back to idle
      '{3'b100, 10, 1'b0, 1'b0},   // dir toggle
      '{3'b101, 10, 1'b1, 1'b1},   // run + dir together
      '{3'b010, 10, 1'b1, 1'b1},   // step ignored in run
      '{3'b001, 10, 1'b0, 1'b1}    // stop
    };

    reset = 1'b0;
    set_btn(3'b000);
    count = 4'd5;
    model_clear();
    @(posedge clk);
    #1;
    do_reset(2);

    hold(3'b000, 50);
    check("idle50_enable", enable, 0);
    check("idle50_dir", count_dir, 1);

    for (int i = 0; i < 8; i++) begin
      hold(vecs[i].btn, vecs[i].hold_n);
      hold(3'b000, 12);
      check($sformatf("vec%0d_enable", i), enable, vecs[i].exp_en);
      check($sformatf("vec%0d_dir", i), count_dir, vecs[i].exp_dir);
    end

    // Latency: run and dir rise together; both outputs move on edge DB+4.
    first_en  = 0;
    first_dir = 0;
    set_btn(3'b101);
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (enable && first_en == 0) first_en = e;
      if (!count_dir && first_dir == 0) first_dir = e;
    end
    check("latency_enable_edge", first_en, DB + 4);
    check("latency_dir_edge", first_dir, DB + 4);
    hold(3'b000, 12);
    check("run_held_after_release", enable, 1);
    hold(3'b001, 10);
    hold(3'b000, 12);

    hi = 0;
    set_btn(3'b010);
    for (int i = 0; i < 22; i++) begin
      if (i == 10) set_btn(3'b000);
      tick();
      hi += int'(enable);
    end
    check("step_pulse_idle_cycles", hi, 1);

    hold(3'b001, 10);
    hold(3'b000, 12);
    hi = 0;
    set_btn(3'b010);
    for (int i = 0; i < 22; i++) begin
      if (i == 10) set_btn(3'b000);
      tick();
      hi += int'(enable);
    end
    check("step_in_run_cycles", hi, 22);

    // Still in RUN with count_dir=0: end-point behaviour.
    count = 4'h0;
    tick();
    check("auto_rev_at_zero", count_dir, AUTO ? 1 : 0);
    count = 4'hF;
    tick();
    check("auto_rev_at_f", count_dir, AUTO ? 0 : (AUTO ? 1 : 0));
    count = 4'd5;

    tick();
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check("midcycle_reset_enable", enable, 0);
    check("midcycle_reset_dir", count_dir, 1);
    tick();
    tick();
    reset = 1'b0;
    hold(3'b000, 5);
    check("resume_idle", enable, 0);
    hold(3'b001, 10);
    hold(3'b000, 12);
    check("run_after_reset", enable, 1);

    set_btn(3'b001);
    tick();
    tick();
    tick();
    set_btn(3'b000);
    do_reset(2);
    hold(3'b000, 15);
    check("mid_debounce_reset_discarded", enable, 0);

    set_btn(3'b001);
    tick();
    do_reset(3);
    hold(3'b001, 12);
    check("held_across_reset_press", enable, 1);
    hold(3'b000, 12);
    check("held_across_reset_single", enable, 1);

    for (int b = 0; b < 3; b++) begin
      rem[b] = 0;
      val[b] = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          val[b] = 1'($urandom_range(0, 1));
          rem[b] = $urandom_range(1, 14);
        end
        rem[b]--;
      end
      set_btn({val[2], val[1], val[0]});
      case ($urandom_range(0, 3))
        0:       count = 4'h0;
        1:       count = 4'hF;
        default: count = 4'($urandom_range(0, 15));
      endcase
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The block SHALL have a parameter DB_CYCLES, default 4, setting the number of consecutive stable cycles needed to accept a button level change (legal range 2..255).
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all flops use its rising edge.
REQ-003 The block SHALL have a port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have a port btn_run, input, 1 bit: raw, asynchronous run/stop pushbutton, active-high.
REQ-005 The block SHALL have a port btn_step, input, 1 bit: raw, asynchronous single-step pushbutton, active-high.
REQ-006 The block SHALL have a port btn_dir, input, 1 bit: raw, asynchronous direction-toggle pushbutton, active-high.
REQ-007 The block SHALL have a port count, input, 4 bits: current value fed back from the downstream 4-bit up/down counter.
REQ-008 The block SHALL have a port enable, output, 1 bit, registered: count enable driven to the counter.
REQ-009 The block SHALL have a port count_dir, output, 1 bit, registered: direction driven to the counter (1 = up, 0 = down).

Function
REQ-010 Each button SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-011 Debounce SHALL be per button: a counter increments while the synchronized value differs from the debounced level, and clears whenever they match.
REQ-012 The debounced level SHALL take the synchronized value on the edge at which the debounce counter would reach DB_CYCLES.
REQ-013 A registered 1-cycle press pulse SHALL be generated on each 0->1 transition of a debounced level; a 1->0 transition SHALL generate nothing.
REQ-014 Latency: outputs SHALL update on the (DB_CYCLES+4)th rising edge after a raw button rises, provided the button is held until then.
REQ-015 The FSM SHALL have the states IDLE (enable=0), RUN (enable=1) and STEP (enable=1).
REQ-016 In IDLE, a run press SHALL move to RUN and a step press SHALL move to STEP.
REQ-017 STEP SHALL last exactly one cycle and then return to IDLE unconditionally, so enable is high for exactly one cycle.
REQ-018 In RUN, a run press SHALL move to IDLE, and a step press SHALL be ignored.
REQ-019 In STEP, run and step presses SHALL be ignored.
REQ-020 If run and step presses occur in the same cycle in IDLE, run SHALL win and the FSM SHALL move to RUN.
REQ-021 A dir press SHALL toggle count_dir in any FSM state, independently of and concurrently with any run or step action.
REQ-022 A button held high SHALL produce exactly one press; a new press requires a debounced release first.
REQ-023 Glitches shorter than DB_CYCLES synchronized cycles SHALL produce no output change.

Reset
REQ-024 Asserting reset SHALL immediately, without waiting for clk, force enable=0, count_dir=1, FSM=IDLE, and clear all synchronizer flops, debounced levels, debounce counters and press pulses.
REQ-025 Reset asserted mid-debounce or mid-STEP SHALL discard that operation; no press SHALL be generated from pre-reset activity.
REQ-026 A button held high across reset release SHALL be debounced from level 0 and SHALL produce one press.

Configuration
REQ-027 When the macro AUTO_REVERSE_EN is defined, count_dir SHALL clear on the next edge if enable=1, count_dir=1 and count=4'hF, and SHALL set on the next edge if enable=1, count_dir=0 and count=4'h0.
REQ-028 With AUTO_REVERSE_EN defined, a dir press in the same cycle as an auto-reverse condition SHALL take priority and toggle the current count_dir, with no auto-reverse applied that cycle.
REQ-029 When AUTO_REVERSE_EN is undefined, the count port SHALL remain present but unused, and count_dir SHALL change only on dir presses, so the counter wraps.

Verification (DB_CYCLES=4)
REQ-030 Reset pulse with no buttons -> enable=0 and count_dir=1 asynchronously, holding for 50 cycles.
REQ-031 btn_run high for 3 cycles -> no change; btn_run high for 10 cycles -> enable=1 at the 8th edge after the rise and staying 1 after release; a second 10-cycle press -> enable=0.
REQ-032 In IDLE, btn_step held for 10 cycles -> enable high for exactly 1 cycle; the same stimulus in RUN -> enable stays 1.
REQ-033 btn_dir press -> count_dir 1->0; btn_run and btn_dir rising in the same cycle from IDLE -> enable=1 and count_dir toggles on the same edge.
REQ-034 With AUTO_REVERSE_EN: RUN, up, count=F -> count_dir=0 on the next edge; down, count=0 -> count_dir=1. Without the macro, the same stimulus -> count_dir unchanged.
REQ-035 reset asserted mid-cycle while in RUN -> enable=0 before the next clk edge; the FSM resumes in IDLE.
